// File: rtl/switch_pkg.sv
// Shared types for the switch output-port queue.
package switch_pkg;

  localparam int unsigned DATA_W = 8;

  // One FIFO entry: the byte plus its end-of-packet marker.
  typedef struct packed {
    logic              eop;
    logic [DATA_W-1:0] data;
  } q_entry_t;

  // Port-side presentation state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } out_state_e;

  // Input framing state: between packets or inside one.
  typedef enum logic {
    OUT_PKT = 1'b0,
    IN_PKT  = 1'b1
  } in_state_e;

endpackage

// File: rtl/switch_out_queue_sync_fifo.sv
// Synchronous show-ahead FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Status flags, guarded push/pop and next pointer values.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/switch_out_queue.sv
// Store-and-forward output queue: buffers framed bytes from the switch core
// and presents only complete packets on the port, one ready pulse per packet.
module switch_out_queue #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DATA_W = switch_pkg::DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_sop,
  input  logic                       in_eop,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          data,
  output logic                       ready,
  input  logic                       read,
  output logic [$clog2(DEPTH+1)-1:0] pkt_count,
  output logic                       proto_err
);

  import switch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH+1);

  out_state_e    out_state_q, out_state_d;
  in_state_e     in_state_q,  in_state_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          proto_err_q, proto_err_d;

  logic          fifo_full, fifo_empty;
  q_entry_t      wr_entry, head_entry;
  logic          accept, push, pop;
  logic          pkt_inc, pkt_dec;
  logic          framing_err, overflow_err;

  sync_fifo #(
    .WIDTH ($bits(q_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_entry)
  );

  // Input framing: drop bytes arriving outside a packet, flag stray sops.
  always_comb begin
    in_ready      = !rst && !fifo_full;
    accept        = in_valid && in_ready;
    push          = 1'b0;
    framing_err   = 1'b0;
    in_state_d    = in_state_q;
    wr_entry.eop  = in_eop;
    wr_entry.data = in_data;
    if (accept) begin
      case (in_state_q)
        OUT_PKT: begin
          if (in_sop) begin
            push       = 1'b1;
            in_state_d = in_eop ? OUT_PKT : IN_PKT;
          end else begin
            framing_err = 1'b1;
          end
        end
        IN_PKT: begin
          push        = 1'b1;
          framing_err = in_sop;
          if (in_eop) in_state_d = OUT_PKT;
        end
        default: in_state_d = OUT_PKT;
      endcase
    end
    pkt_inc = push && in_eop;
  end

  // Output presentation: IDLE waits for a whole packet, SEND streams it,
  // GAP forces one low cycle of ready between packets.
  always_comb begin
    out_state_d = out_state_q;
    ready       = (out_state_q == SEND);
    data        = head_entry.data;
    pop         = ready && read && !fifo_empty;
    pkt_dec     = pop && head_entry.eop;
    case (out_state_q)
      IDLE: if (pkt_count_q != '0) out_state_d = SEND;
      SEND: if (pkt_dec) out_state_d = GAP;
      GAP:  out_state_d = (pkt_count_q != '0) ? SEND : IDLE;
      default: out_state_d = IDLE;
    endcase
  end

  // Packet accounting and sticky protocol error; an over-long packet shows
  // up as a full FIFO with no complete packet behind the open frame.
  always_comb begin
    pkt_count_d  = pkt_count_q + {{(CW-1){1'b0}}, pkt_inc}
                               - {{(CW-1){1'b0}}, pkt_dec};
    overflow_err = fifo_full && (pkt_count_q == '0) && (in_state_q == IN_PKT);
    proto_err_d  = proto_err_q || framing_err || overflow_err;
    pkt_count    = pkt_count_q;
    proto_err    = proto_err_q;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state_q <= IDLE;
      in_state_q  <= OUT_PKT;
      pkt_count_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      out_state_q <= out_state_d;
      in_state_q  <= in_state_d;
      pkt_count_q <= pkt_count_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_switch_out_queue.sv
// Bench for switch_out_queue: directed scenarios followed by random traffic,
// all compared against a byte-queue reference model.
module tb_switch_out_queue;

  localparam int unsigned DEPTH = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic       in_ready;
  logic [7:0] data;
  logic       ready;
  logic       read = 1'b0;
  logic [6:0] pkt_count;
  logic       proto_err;

  switch_out_queue #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .data      (data),
    .ready     (ready),
    .read      (read),
    .pkt_count (pkt_count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: buffered {eop,byte} entries, complete packet count,
  // sticky error, open-frame flag and the port's ready level.
  bit [8:0] mq[$];
  int       mcount = 0;
  bit       merr   = 1'b0;
  bit       mframe = 1'b0;
  bit       mready = 1'b0;
  bit [7:0] popped[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, then compare.
  task automatic cyc(input bit v, input bit [7:0] d, input bit s, input bit e,
                     input bit r, input bit rs);
    bit acc, pp, eop_pop, nready;
    in_valid = v; in_data = d; in_sop = s; in_eop = e; read = r; rst = rs;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!rs && (mq.size() < DEPTH)));
    if (rs) begin
      mq.delete(); mcount = 0; merr = 0; mframe = 0; mready = 0;
    end else begin
      acc     = v && (mq.size() < DEPTH);
      pp      = mready && r;
      eop_pop = pp && mq[0][8];
      // ready stays up until the eop byte leaves; once low, it returns the
      // cycle after a complete packet is counted
      nready  = mready ? !eop_pop : (mcount > 0);
      if (mq.size() == DEPTH && mcount == 0 && mframe) merr = 1;
      if (pp) begin
        popped.push_back(mq[0][7:0]);
        void'(mq.pop_front());
        if (eop_pop) mcount--;
      end
      if (acc) begin
        if (!mframe && !s) merr = 1;
        else begin
          if (mframe && s) merr = 1;
          mq.push_back({e, d});
          if (e) begin mcount++; mframe = 0; end
          else mframe = 1;
        end
      end
      mready = nready;
    end
    @(posedge clk);
    #1;
    chk("ready", 32'(ready), 32'(mready));
    chk("pkt_count", 32'(pkt_count), 32'(mcount));
    chk("proto_err", 32'(proto_err), 32'(merr));
    if (mready) chk("data", 32'(data), 32'(mq[0][7:0]));
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, 0, r, 0);
  endtask

  initial begin
    bit       v, s, e, r, rs;
    bit [7:0] d;
    int       glen;

    // reset
    cyc(0, 8'h00, 0, 0, 0, 1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);

    // 4-byte packet, then drain with read held high
    cyc(1, 8'hA0, 1, 0, 0, 0);
    cyc(1, 8'hA1, 0, 0, 0, 0);
    cyc(1, 8'hA2, 0, 0, 0, 0);
    cyc(1, 8'hA3, 0, 1, 0, 0);
    chk("pktA_count", 32'(pkt_count), 32'd1);
    chk("pktA_not_ready_yet", 32'(ready), 32'd0);
    popped.delete();
    cyc(0, 8'h00, 0, 0, 1, 0);
    chk("pktA_ready", 32'(ready), 32'd1);
    idle(6, 1);
    chk("pktA_len", 32'(popped.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk("pktA_byte", 32'(popped[i]), 32'(8'hA0 + i));
    chk("pktA_idle_count", 32'(pkt_count), 32'd0);

    // two back-to-back packets {11,12} and {21}
    popped.delete();
    cyc(1, 8'h11, 1, 0, 1, 0);
    cyc(1, 8'h12, 0, 1, 1, 0);
    cyc(1, 8'h21, 1, 1, 1, 0);
    idle(6, 1);
    chk("b2b_len", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("b2b_0", 32'(popped[0]), 32'h11);
      chk("b2b_1", 32'(popped[1]), 32'h12);
      chk("b2b_2", 32'(popped[2]), 32'h21);
    end

    // DEPTH-byte packet fills the FIFO exactly
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 8'(i), i == 0, i == DEPTH - 1, 0, 0);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    idle(DEPTH + 4, 1);
    chk("drained_in_ready", 32'(in_ready), 32'd1);
    chk("drained_count", 32'(pkt_count), 32'd0);

    // eop write coincides with eop pop
    cyc(1, 8'h31, 1, 0, 1, 0);
    cyc(1, 8'h32, 0, 1, 1, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(1, 8'h41, 1, 0, 1, 0);
    cyc(1, 8'h42, 0, 1, 1, 0);
    chk("coinc_count", 32'(pkt_count), 32'd1);
    chk("coinc_gap", 32'(ready), 32'd0);
    cyc(0, 8'h00, 0, 0, 0, 0);
    chk("coinc_send", 32'(ready), 32'd1);
    // holding read low keeps the head byte in place
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0, 0, 0, 0);
      chk("hold_data", 32'(data), 32'h41);
    end
    idle(4, 1);

    // byte without sop outside a packet is dropped and flags an error
    cyc(1, 8'h55, 0, 0, 0, 0);
    chk("drop_err", 32'(proto_err), 32'd1);
    chk("drop_count", 32'(pkt_count), 32'd0);
    idle(3, 1);

    // reset during a drain discards everything
    cyc(1, 8'h61, 1, 0, 0, 0);
    cyc(1, 8'h62, 0, 0, 0, 0);
    cyc(1, 8'h63, 0, 1, 0, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 1, 0);
    cyc(0, 8'h00, 0, 0, 1, 1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_count", 32'(pkt_count), 32'd0);
    chk("midrst_err", 32'(proto_err), 32'd0);
    idle(2, 1);

    // over-long packet: FIFO full with the frame still open
    for (int i = 0; i < DEPTH; i++)
      cyc(1, 8'(i ^ 8'h5A), i == 0, 0, 0, 0);
    idle(1, 0);
    chk("overflow_err", 32'(proto_err), 32'd1);
    cyc(0, 8'h00, 0, 0, 0, 1);
    idle(1, 0);

    // random traffic with occasional framing violations and resets
    glen = 0;
    for (int n = 0; n < 3000; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 499) == 0);
      d  = 8'($urandom);
      s  = mframe ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 49) != 0);
      e  = mframe ? (glen >= 20 || $urandom_range(0, 5) == 0)
                  : ($urandom_range(0, 4) == 0);
      if (rs) glen = 0;
      else if (v && mq.size() < DEPTH) begin
        if (!mframe && s) glen = e ? 0 : 1;
        else if (mframe) glen = e ? 0 : glen + 1;
      end
      cyc(v, d, s, e, r, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
